// File: rtl/buzzer_arbiter.sv
// Priority arbiter sharing one buzzer frequency divider among three tone requesters.
// Each grant plays its latched frequency for a latched number of milliseconds.
module buzzer_arbiter #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [31:0] freq0,
  input  logic [31:0] freq1,
  input  logic [31:0] freq2,
  input  logic [15:0] dur0,
  input  logic [15:0] dur1,
  input  logic [15:0] dur2,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic [2:0]  abrt,
  output logic        busy,
  output logic [31:0] div_freq,
  output logic        div_rst_n
);

  localparam int unsigned TICK      = CLK_HZ / 1000;
  localparam int unsigned TW        = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);

  typedef enum logic [1:0] {IDLE, GAP, PLAY} state_t;

  state_t        state;
  logic [2:0]    arm;
  logic [1:0]    own;
  logic [15:0]   ms_cnt;
  logic [TW-1:0] tick_cnt;

  logic [2:0]    elig;
  logic          win_any;
  logic [1:0]    win_idx;
  logic [31:0]   freq_sel;
  logic [15:0]   dur_sel;
  logic          own_req;
  logic          tick_wrap;
  logic          finishing;
  logic          start;

  // Arbitration, owner status and completion detection.
  always_comb begin
    elig      = req & arm;
    win_any   = |elig;
    win_idx   = 2'd0;
    freq_sel  = freq0;
    dur_sel   = dur0;
    own_req   = req[0];
    if (elig[0])      win_idx = 2'd0;
    else if (elig[1]) win_idx = 2'd1;
    else if (elig[2]) win_idx = 2'd2;
    case (win_idx)
      2'd1:    begin freq_sel = freq1; dur_sel = dur1; end
      2'd2:    begin freq_sel = freq2; dur_sel = dur2; end
      default: begin freq_sel = freq0; dur_sel = dur0; end
    endcase
    case (own)
      2'd1:    own_req = req[1];
      2'd2:    own_req = req[2];
      default: own_req = req[0];
    endcase
    tick_wrap = (tick_cnt == TICK_LAST);
    finishing = ((state == GAP)  && (ms_cnt == 16'd0)) ||
                ((state == PLAY) && tick_wrap && (ms_cnt == 16'd1));
    // A new grant from IDLE, or a preemption by a lower index that is not masked by completion.
    start     = win_any && ((state == IDLE) || (!finishing && (win_idx < own)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      arm       <= 3'b111;
      own       <= 2'd0;
      ms_cnt    <= 16'd0;
      tick_cnt  <= '0;
      grant     <= 3'b000;
      done      <= 3'b000;
      abrt      <= 3'b000;
      busy      <= 1'b0;
      div_freq  <= 32'd0;
      div_rst_n <= 1'b0;
    end else begin
      done <= 3'b000;
      abrt <= 3'b000;
      arm  <= arm | ~req;
      if (start) begin
        if (state != IDLE) abrt[own] <= 1'b1;
        own          <= win_idx;
        grant        <= 3'b001 << win_idx;
        div_freq     <= freq_sel;
        ms_cnt       <= dur_sel;
        arm[win_idx] <= 1'b0;
        busy         <= 1'b1;
        div_rst_n    <= 1'b0;
        state        <= GAP;
      end else if (state != IDLE) begin
        if (finishing || !own_req) begin
          if (finishing) done[own] <= 1'b1;
          else           abrt[own] <= 1'b1;
          grant     <= 3'b000;
          busy      <= 1'b0;
          div_rst_n <= 1'b0;
          state     <= IDLE;
        end else if (state == GAP) begin
          // Divider stays held in reset for a silent (zero-frequency) tone.
          tick_cnt  <= '0;
          div_rst_n <= |div_freq;
          state     <= PLAY;
        end else if (tick_wrap) begin
          tick_cnt <= '0;
          ms_cnt   <= ms_cnt - 16'd1;
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
    end
  end

endmodule
